// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: merges ALU (A) and load/multicycle (M) writebacks
// onto one registered write port, with an optional post-reset zero-fill of x1..x31.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_CLEAR | zero-fill sweep of x1..x31, one write per cycle, no grants
// ST_RUN   | normal arbitration between sources A and M
module rf_wb_arbiter #(
  parameter bit CLEAR_ON_RESET = 1'b1,
  parameter bit FIXED_PRIO     = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_valid,
  input  logic [4:0]  a_rd,
  input  logic [31:0] a_data,
  output logic        a_ready,
  input  logic        m_valid,
  input  logic [4:0]  m_rd,
  input  logic [31:0] m_data,
  output logic        m_ready,
  output logic        reg_write,
  output logic [4:0]  rd_addr,
  output logic [31:0] wb_data,
  output logic        busy,
  output logic [15:0] conflict_cnt
);

  typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

  state_t      state;
  state_t      state_nxt;
  logic        last_grant_m;
  logic        a_live;
  logic        m_live;
  logic        grant_a;
  logic        grant_m;
  logic        stall;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // rd_addr doubles as the sweep pointer; the last sweep write is on the outputs when it reads 31
  always_comb begin
    state_nxt = state;
    if (state == ST_CLEAR && rd_addr == 5'd31) begin
      state_nxt = ST_RUN;
    end
  end

  always_comb begin
    a_live  = a_valid && (a_rd != 5'd0);
    m_live  = m_valid && (m_rd != 5'd0);
    grant_a = 1'b0;
    grant_m = 1'b0;
    a_ready = 1'b0;
    m_ready = 1'b0;
    stall   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = a_rd;
    wr_data = a_data;
    if (state == ST_RUN) begin
      // A wins a conflict unless round-robin says M is owed the slot
      grant_a = a_live && (!m_live || FIXED_PRIO || last_grant_m);
      grant_m = m_live && !grant_a;
      a_ready = grant_a || (a_valid && a_rd == 5'd0);
      m_ready = grant_m || (m_valid && m_rd == 5'd0);
      stall   = (a_live && !grant_a) || (m_live && !grant_m);
      if (grant_a) begin
        wr_en   = 1'b1;
        wr_addr = a_rd;
        wr_data = a_data;
      end else if (grant_m) begin
        wr_en   = 1'b1;
        wr_addr = m_rd;
        wr_data = m_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write    <= 1'b0;
      rd_addr      <= 5'd0;
      wb_data      <= 32'd0;
      busy         <= 1'b0;
      conflict_cnt <= 16'd0;
      last_grant_m <= 1'b1;
    end else begin
      busy <= (state_nxt == ST_CLEAR);
      if (state == ST_CLEAR) begin
        if (rd_addr != 5'd31) begin
          reg_write <= 1'b1;
          rd_addr   <= rd_addr + 5'd1;
          wb_data   <= 32'd0;
        end else begin
          reg_write <= 1'b0;
        end
      end else begin
        reg_write <= wr_en;
        if (wr_en) begin
          rd_addr      <= wr_addr;
          wb_data      <= wr_data;
          last_grant_m <= grant_m;
        end
        if (stall && conflict_cnt != 16'hFFFF) begin
          conflict_cnt <= conflict_cnt + 16'd1;
        end
      end
    end
  end

endmodule
